// File: rtl/cordic_rotation_iter.sv
// Iterative CORDIC rotation: one micro-rotation per clock, angle steps read from an external atan LUT.
// Build macro CORDIC_GAIN_COMP_EN adds a COMP state that scales x/y by 1/K (CORDIC gain removal).
module cordic_rotation_iter #(
  parameter int unsigned DSIZE = 16,
  parameter int unsigned ITER  = 16
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DSIZE-1:0] x_in,
  input  logic signed [DSIZE-1:0] y_in,
  input  logic        [DSIZE-1:0] z_in,
  output logic        [4:0]       lut_index,
  input  logic        [DSIZE-1:0] lut_dz,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DSIZE+1:0] x_out,
  output logic signed [DSIZE+1:0] y_out,
  output logic signed [DSIZE+1:0] z_out
);

  localparam int unsigned W = DSIZE + 2;

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROT = 2'd1, S_DONE = 2'd2, S_COMP = 2'd3} state_t;

  localparam int unsigned PW = W + DSIZE + 1;
  localparam logic [DSIZE:0] GAIN_K = (DSIZE+1)'($rtoi(0.607252935 * (2.0 ** DSIZE) + 0.5));
  localparam logic signed [PW-1:0] ROUND_HALF = PW'(1) <<< (DSIZE - 1);

  // v * K with the product's low DSIZE bits rounded half-up away
  function automatic logic signed [W-1:0] gain_comp(input logic signed [W-1:0] v);
    logic signed [PW-1:0] p;
    p = PW'(v) * PW'(signed'({1'b0, GAIN_K}));
    return W'((p + ROUND_HALF) >>> DSIZE);
  endfunction
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROT = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t               state_q, state_d;
  logic [4:0]           i_q, i_d;
  logic signed [W-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [W-1:0]  x_sh, y_sh, dz;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    x_sh    = x_q >>> i_q;
    y_sh    = y_q >>> i_q;
    dz      = signed'(W'(lut_dz));
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_ROT;
          x_d     = W'(x_in);
          y_d     = W'(y_in);
          z_d     = signed'(W'(z_in));
          i_d     = '0;
        end
      end
      S_ROT: begin
        // rotate toward z = 0; the sign bit of z picks the direction
        if (!z_q[W-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - dz;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + dz;
        end
        if (i_q == 5'(ITER - 1)) begin
          i_d = '0;
`ifdef CORDIC_GAIN_COMP_EN
          state_d = S_COMP;
`else
          state_d = S_DONE;
`endif
        end else begin
          i_d = i_q + 5'd1;
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_COMP: begin
        x_d     = gain_comp(x_q);
        y_d     = gain_comp(y_q);
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign lut_index = i_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;

endmodule

// File: doc/cordic_rotation_iter.md
CORDIC_ROTATION_ITER -- requirements
Module: cordic_rotation_iter

Interface
REQ-001 SHALL have parameter DSIZE, default 16, giving the angle/data width; the angle scale is a full DSIZE word = 90 degrees.
REQ-002 SHALL have parameter ITER, default 16, giving the number of micro-rotations; legal range 1..32.
REQ-003 SHALL have port clock, input, 1, the only clock, with all state updating on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, which qualifies x_in/y_in/z_in.
REQ-006 SHALL have port in_ready, output, 1, which indicates the block accepts a new vector.
REQ-007 SHALL have ports x_in and y_in, input, DSIZE, signed start vector.
REQ-008 SHALL have port z_in, input, DSIZE, unsigned rotation angle in [0, 90) degrees.
REQ-009 SHALL have port lut_index, output, 5, the arctangent table index driven to the downstream angle LUT.
REQ-010 SHALL have port lut_dz, input, DSIZE, the unsigned atan(2^-lut_index) returned combinationally by the LUT in the same cycle.
REQ-011 SHALL have port out_valid, output, 1, which qualifies the result.
REQ-012 SHALL have port out_ready, input, 1, the consumer acceptance signal.
REQ-013 SHALL have ports x_out and y_out, output, DSIZE+2, signed rotated vector.
REQ-014 SHALL have port z_out, output, DSIZE+2, signed residual angle.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE -> ROT on in_valid&in_ready; ROT -> DONE after ITER iterations; DONE -> IDLE on out_valid&out_ready.
REQ-016 SHALL drive in_ready=1 only in IDLE and SHALL NOT bypass DONE -> IDLE -> accept within one cycle.
REQ-017 SHALL, on accept, load x,y sign-extended to DSIZE+2 bits, load z zero-extended to DSIZE+2 bits, and clear the iteration counter i to 0.
REQ-018 SHALL, in ROT, drive lut_index=i and register per cycle: d=+1 if z>=0 else -1; x'=x-d*(y>>>i); y'=y+d*(x>>>i); z'=z-d*lut_dz (zero-extended), using arithmetic shifts and two's-complement wrap at DSIZE+2 bits.
REQ-019 SHALL drive lut_index=0 in IDLE and DONE.
REQ-020 SHALL increment i each ROT cycle and leave ROT on the cycle that processes i=ITER-1.
REQ-021 SHALL assert out_valid exactly ITER+1 cycles after the accept edge (macro off).
REQ-022 SHALL hold out_valid and x_out/y_out/z_out stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-023 SHALL ignore in_valid outside IDLE, and SHALL ignore out_ready outside DONE.
REQ-024 SHALL leave uncompensated outputs carrying CORDIC gain approximately 1.64676.

Reset
REQ-025 SHALL, on rst=1 at a clock edge in any state, set state IDLE, i=0, out_valid=0, in_ready=1 from the next cycle, lut_index=0, and x_out=y_out=z_out=0.
REQ-026 SHALL discard an in-flight operation on reset mid-ROT or in DONE, with no out_valid pulse.
REQ-027 SHALL give rst priority over in_valid when both are asserted at the same edge.

Configuration
REQ-028 SHALL, with macro CORDIC_GAIN_COMP_EN defined, add one COMP state between ROT and DONE that multiplies x and y by K=round(0.607252935*2^DSIZE), keeping bits [2*DSIZE+1:DSIZE] with round-half-up, making latency ITER+2 cycles.
REQ-029 SHALL, without CORDIC_GAIN_COMP_EN, contain no multiplier and no COMP state, with latency ITER+1 cycles.

Verification (DSIZE=16, ITER=16)
REQ-030 SHALL cover: x_in=10000, y_in=0, z_in=32768 (45 deg), macro off -> x_out≈11644, y_out≈11644 (±4), |z_out|<=8.
REQ-031 SHALL cover: the same stimulus with macro on -> x_out≈7071, y_out≈7071 (±4), out_valid 18 cycles after accept.
REQ-032 SHALL cover: x_in=10000, y_in=0, z_in=0, macro off -> x_out≈16468 (±4), |y_out|<=4, and lut_index stepping 0..15 on consecutive ROT cycles.
REQ-033 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> outputs unchanged and in_ready=0 throughout; out_ready=1 -> in_ready=1 on the next cycle.
REQ-034 SHALL cover: rst pulsed during iteration 5 -> next cycle out_valid=0, in_ready=1, lut_index=0, outputs 0, and a fresh vector then completes correctly.
REQ-035 SHALL cover: back-to-back vectors with in_valid held 1 -> second accept occurs exactly one cycle after the first handshake completes, and both results are correct.
